// File: rtl/alu_arb_pkg.sv
// Shared types and widths for the ALU arbiter: FSM state encoding and ALU port widths.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int ALU_W = 8;
  localparam int OP_W  = 3;
  localparam int OUT_W = 16;

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping modulo N_REQ.
module rr_picker
  import alu_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             valid,
  output logic [IDX_W-1:0] winner
);

  // Scan offsets from farthest to nearest so the nearest requester overwrites earlier candidates.
  always_comb begin
    valid  = 1'b0;
    winner = {IDX_W{1'b0}};
    for (int k = N_REQ - 1; k >= 0; k--) begin
      int idx;
      idx    = (int'(rr_ptr) + k) % N_REQ;
      valid  = valid | req[idx];
      winner = req[idx] ? IDX_W'(idx) : winner;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one multi-cycle ALU between N_REQ requesters: round-robin pick, operand latch,
// start pulse, completion wait with timeout and one-hot response routing.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [ALU_W*N_REQ-1:0] req_x,
  input  logic [ALU_W*N_REQ-1:0] req_y,
  input  logic [OP_W*N_REQ-1:0]  req_op,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [OUT_W-1:0]       rsp_data,
  output logic                   rsp_err,
  output logic [ALU_W-1:0]       alu_x,
  output logic [ALU_W-1:0]       alu_y,
  output logic [OP_W-1:0]        alu_op,
  output logic                   alu_begin,
  input  logic                   alu_end,
  input  logic [OUT_W-1:0]       alu_out,
  output logic                   busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [CNT_W-1:0] cnt;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] next_ptr;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = {N_REQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  assign next_ptr = (pick_idx == IDX_W'(N_REQ - 1)) ? {IDX_W{1'b0}} : pick_idx + IDX_W'(1);

  // Arbitration FSM with registered grant, ALU drive and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= {IDX_W{1'b0}};
      owner     <= {IDX_W{1'b0}};
      cnt       <= {CNT_W{1'b0}};
      gnt       <= {N_REQ{1'b0}};
      rsp_valid <= {N_REQ{1'b0}};
      rsp_data  <= {OUT_W{1'b0}};
      rsp_err   <= 1'b0;
      alu_x     <= {ALU_W{1'b0}};
      alu_y     <= {ALU_W{1'b0}};
      alu_op    <= {OP_W{1'b0}};
      alu_begin <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          gnt       <= {N_REQ{1'b0}};
          rsp_valid <= {N_REQ{1'b0}};
          alu_begin <= 1'b0;
          if (pick_valid) begin
            alu_x     <= req_x[pick_idx*ALU_W +: ALU_W];
            alu_y     <= req_y[pick_idx*ALU_W +: ALU_W];
            alu_op    <= req_op[pick_idx*OP_W +: OP_W];
            owner     <= pick_idx;
            rr_ptr    <= next_ptr;
            gnt       <= onehot(pick_idx);
            alu_begin <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          gnt       <= {N_REQ{1'b0}};
          alu_begin <= 1'b0;
          cnt       <= {CNT_W{1'b0}};
          state     <= WAIT;
        end
        WAIT: begin
          // Completion is checked first so END on the final timeout cycle still succeeds.
          if (alu_end) begin
            rsp_data  <= alu_out;
            rsp_err   <= 1'b0;
            rsp_valid <= onehot(owner);
            state     <= DRAIN;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            rsp_data  <= {OUT_W{1'b0}};
            rsp_err   <= 1'b1;
            rsp_valid <= onehot(owner);
            state     <= DRAIN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          rsp_valid <= {N_REQ{1'b0}};
          if (!alu_end) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          gnt       <= {N_REQ{1'b0}};
          rsp_valid <= {N_REQ{1'b0}};
          alu_begin <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
